// File: rtl/fcfs_slice_scheduler_if.sv
// Requester-side bus of the FCFS slice scheduler: request/weight/release lines in,
// one-hot grant, grant index, queue depth and starvation flag out.
interface fcfs_slice_scheduler_if #(
  parameter int Requestors = 4
);
  localparam int IW = $clog2(Requestors);

  logic [Requestors-1:0]       req;
  logic [Requestors-1:0][7:0]  weights;
  logic                        release_i;
  logic [Requestors-1:0]       grant;
  logic                        grant_valid;
  logic [IW-1:0]               grant_id;
  logic [IW:0]                 q_count;
  logic                        starve_err;

  modport master (
    output req, weights, release_i,
    input  grant, grant_valid, grant_id, q_count, starve_err
  );

  modport slave (
    input  req, weights, release_i,
    output grant, grant_valid, grant_id, q_count, starve_err
  );
endinterface

// File: rtl/fcfs_slice_scheduler.sv
// First-come-first-served time-slice scheduler with weighted slices and tail re-entry.
// Optional starvation watchdog is built only when FCFS_STARVE_CHK_EN is defined.
module fcfs_slice_scheduler #(
  parameter int Requestors   = 4,
  parameter int QUANTUM      = 10,
  parameter int STARVE_LIMIT = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  fcfs_slice_scheduler_if.slave  bus
);
  localparam int IW = $clog2(Requestors);
  localparam int SW = $clog2(255 * QUANTUM + 1);
  localparam logic [SW-1:0] QUANT_SW = SW'(QUANTUM);
  localparam logic [IW:0]   CNT_ONE  = (IW+1)'(1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t                state, state_next;
  logic [IW-1:0]         q_mem      [Requestors];
  logic [IW-1:0]         q_mem_next [Requestors];
  logic [IW-1:0]         head, head_next, tail, tail_next;
  logic [IW:0]           count, count_next;
  logic [Requestors-1:0] in_q, in_q_next, enq;
  logic [Requestors-1:0] grant;
  logic [IW-1:0]         grant_id;
  logic                  grant_valid;
  logic [SW-1:0]         slice_cnt, slice_load;
  logic [IW-1:0]         head_id;
  logic                  head_req;
  logic [7:0]            w_eff;
  logic                  do_pop, start_grant, end_grant;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
    if (p == IW'(Requestors - 1)) return '0;
    return p + IW'(1);
  endfunction

  assign grant_valid = |grant;
  assign head_id     = q_mem[head];
  assign head_req    = bus.req[head_id];
  assign w_eff       = (bus.weights[head_id] == 8'd0) ? 8'd1 : bus.weights[head_id];
  assign slice_load  = SW'(w_eff) * QUANT_SW - SW'(1);

  // The active requester is kept out of the queue until its slice has ended.
  always_comb begin
    for (int i = 0; i < Requestors; i++) begin
      enq[i] = bus.req[i] && !in_q[i] && !(grant_valid && grant_id == IW'(i));
    end
  end

  always_comb begin
    state_next  = state;
    do_pop      = 1'b0;
    start_grant = 1'b0;
    end_grant   = 1'b0;
    case (state)
      IDLE, GAP: begin
        state_next = IDLE;
        if (count != '0) begin
          do_pop = 1'b1;
          if (head_req) begin
            start_grant = 1'b1;
            state_next  = GRANT;
          end
        end
      end
      GRANT: begin
        if (slice_cnt == '0 || !bus.req[grant_id] || bus.release_i) begin
          end_grant  = 1'b1;
          state_next = GAP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pop uses the pre-edge head; new arrivals land behind it in ascending index order.
  always_comb begin
    q_mem_next = q_mem;
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    in_q_next  = in_q;
    if (do_pop) begin
      head_next          = wrap_inc(head);
      count_next         = count - CNT_ONE;
      in_q_next[head_id] = 1'b0;
    end
    for (int i = 0; i < Requestors; i++) begin
      if (enq[i]) begin
        q_mem_next[tail_next] = IW'(i);
        tail_next             = wrap_inc(tail_next);
        count_next            = count_next + CNT_ONE;
        in_q_next[i]          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      in_q  <= '0;
      for (int i = 0; i < Requestors; i++) q_mem[i] <= '0;
    end else begin
      state <= state_next;
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
      in_q  <= in_q_next;
      q_mem <= q_mem_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant     <= '0;
      grant_id  <= '0;
      slice_cnt <= '0;
    end else if (start_grant) begin
      grant     <= Requestors'(1) << head_id;
      grant_id  <= head_id;
      slice_cnt <= slice_load;
    end else if (end_grant) begin
      grant     <= '0;
    end else if (state == GRANT) begin
      slice_cnt <= slice_cnt - SW'(1);
    end
  end

`ifdef FCFS_STARVE_CHK_EN
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  logic [Requestors-1:0][WW-1:0] wait_cnt;
  logic                          starve_hit, starve_q;

  always_comb begin
    starve_hit = 1'b0;
    for (int i = 0; i < Requestors; i++) begin
      if (wait_cnt[i] == WW'(STARVE_LIMIT)) starve_hit = 1'b1;
    end
  end

  // Wait counters saturate at the limit and restart once the entry leaves the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      starve_q <= 1'b0;
    end else begin
      for (int i = 0; i < Requestors; i++) begin
        if (!in_q[i]) wait_cnt[i] <= '0;
        else if (wait_cnt[i] != WW'(STARVE_LIMIT)) wait_cnt[i] <= wait_cnt[i] + WW'(1);
      end
      starve_q <= starve_q | starve_hit;
    end
  end

  assign bus.starve_err = starve_q;
`else
  assign bus.starve_err = 1'b0;
`endif

  assign bus.grant       = grant;
  assign bus.grant_valid = grant_valid;
  assign bus.grant_id    = grant_id;
  assign bus.q_count     = count;
endmodule

// File: tb/tb_fcfs_slice_scheduler.sv
// Directed bench for fcfs_slice_scheduler (N=4, QUANTUM=10): latency, slice lengths,
// FCFS ordering, early termination, stale-entry discard and mid-slice reset.
module tb_fcfs_slice_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   len;

  always #5 clk = ~clk;

  fcfs_slice_scheduler_if #(.Requestors(4)) bus();

  fcfs_slice_scheduler #(
    .Requestors(4),
    .QUANTUM(10),
    .STARVE_LIMIT(1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rel);
    bus.req       = r;
    bus.release_i = rel;
  endtask

  // Counts high cycles starting at the current one; returns on the first low cycle.
  task automatic sliceLen(output int n);
    n = 0;
    while (bus.grant_valid && n < 400) begin
      n++;
      tick();
    end
  endtask

  // Counts low cycles starting at the current one; returns on the first high cycle.
  task automatic gapLen(output int n);
    n = 0;
    while (!bus.grant_valid && n < 400) begin
      n++;
      tick();
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_grant"}, 32'(bus.grant), 32'd0);
    checkOutput({tag, "_qcnt"}, 32'(bus.q_count), 32'd0);
  endtask

  initial begin
    int exp_ids [6] = '{1, 3, 0, 1, 3, 0};

    reset = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) bus.weights[i] = 8'd1;
    settle(2);
    checkOutput("rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("rst_valid", 32'(bus.grant_valid), 32'd0);
    checkOutput("rst_id", 32'(bus.grant_id), 32'd0);
    checkOutput("rst_qcnt", 32'(bus.q_count), 32'd0);
    checkOutput("rst_starve", 32'(bus.starve_err), 32'd0);
    reset = 1'b1;
    tick();

    // Single requester: 2-edge latency, slice length follows weight sampled at grant start.
    applyStimulus(4'b0100, 1'b0);
    tick();
    checkOutput("t2_enq_qcnt", 32'(bus.q_count), 32'd1);
    checkOutput("t2_enq_grant", 32'(bus.grant), 32'd0);
    tick();
    checkOutput("t2_grant", 32'(bus.grant), 32'b0100);
    checkOutput("t2_id", 32'(bus.grant_id), 32'd2);
    checkOutput("t2_qcnt_act", 32'(bus.q_count), 32'd0);
    sliceLen(len); checkOutput("t2_slice_w1", 32'(len), 32'd10);
    gapLen(len);   checkOutput("t2_gap_a", 32'(len), 32'd2);
    bus.weights[2] = 8'd3;
    sliceLen(len); checkOutput("t2_slice_midchg", 32'(len), 32'd10);
    gapLen(len);   checkOutput("t2_gap_b", 32'(len), 32'd2);
    bus.weights[2] = 8'd0;
    sliceLen(len); checkOutput("t2_slice_w3", 32'(len), 32'd30);
    gapLen(len);   checkOutput("t2_gap_c", 32'(len), 32'd2);
    sliceLen(len); checkOutput("t2_slice_w0", 32'(len), 32'd10);
    applyStimulus(4'b0000, 1'b0);
    bus.weights[2] = 8'd1;
    settle(4);
    checkIdle("t2_end");

    // Staggered arrivals are served in arrival order and rotate with 1-cycle gaps.
    applyStimulus(4'b0010, 1'b0);
    tick();
    applyStimulus(4'b1010, 1'b0);
    tick();
    applyStimulus(4'b1011, 1'b0);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("t3_id%0d", k), 32'(bus.grant_id), 32'(exp_ids[k]));
      sliceLen(len); checkOutput($sformatf("t3_slice%0d", k), 32'(len), 32'd10);
      if (k < 5) begin
        gapLen(len); checkOutput($sformatf("t3_gap%0d", k), 32'(len), 32'd1);
      end
    end
    applyStimulus(4'b0000, 1'b0);
    settle(4);
    checkIdle("t3_end");

    // Simultaneous arrivals enqueue in ascending index order.
    applyStimulus(4'b0011, 1'b0);
    tick();
    checkOutput("t4_qcnt_peak", 32'(bus.q_count), 32'd2);
    tick();
    checkOutput("t4_grant0", 32'(bus.grant), 32'b0001);
    checkOutput("t4_qcnt1", 32'(bus.q_count), 32'd1);
    sliceLen(len); checkOutput("t4_slice", 32'(len), 32'd10);
    gapLen(len);   checkOutput("t4_gap", 32'(len), 32'd1);
    checkOutput("t4_id1", 32'(bus.grant_id), 32'd1);
    checkOutput("t4_requeue", 32'(bus.q_count), 32'd1);
    applyStimulus(4'b0000, 1'b0);
    settle(5);
    checkIdle("t4_end");

    // Dropping req ends the slice at the next edge.
    applyStimulus(4'b0001, 1'b0);
    settle(2);
    checkOutput("t5_grant0", 32'(bus.grant), 32'b0001);
    settle(3);
    checkOutput("t5_cyc4_high", 32'(bus.grant_valid), 32'd1);
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("t5_drop_low", 32'(bus.grant_valid), 32'd0);
    settle(3);
    checkIdle("t5a_end");

    // A release pulse ends the slice; the waiting requester goes next and 0 rejoins behind.
    applyStimulus(4'b0011, 1'b0);
    settle(2);
    checkOutput("t5b_grant0", 32'(bus.grant), 32'b0001);
    settle(2);
    applyStimulus(4'b0011, 1'b1);
    tick();
    applyStimulus(4'b0011, 1'b0);
    checkOutput("t5b_rel_low", 32'(bus.grant_valid), 32'd0);
    checkOutput("t5b_rel_qcnt", 32'(bus.q_count), 32'd1);
    tick();
    checkOutput("t5b_grant1", 32'(bus.grant), 32'b0010);
    checkOutput("t5b_qcnt_0back", 32'(bus.q_count), 32'd1);
    sliceLen(len); checkOutput("t5b_slice1", 32'(len), 32'd10);
    gapLen(len);   checkOutput("t5b_gap", 32'(len), 32'd1);
    checkOutput("t5b_id0", 32'(bus.grant_id), 32'd0);
    applyStimulus(4'b0000, 1'b0);
    settle(5);
    checkIdle("t5b_end");

    // Stale head is discarded and never granted.
    bus.weights[0] = 8'd3;
    applyStimulus(4'b0001, 1'b0);
    settle(2);
    checkOutput("t6_grant0", 32'(bus.grant), 32'b0001);
    applyStimulus(4'b1001, 1'b0);
    tick();
    checkOutput("t6_q3", 32'(bus.q_count), 32'd1);
    tick();
    applyStimulus(4'b0001, 1'b0);
    sliceLen(len); checkOutput("t6_slice_rest", 32'(len), 32'd28);
    gapLen(len);   checkOutput("t6_gap", 32'(len), 32'd2);
    checkOutput("t6_grant_again0", 32'(bus.grant), 32'b0001);
    checkOutput("t6_qcnt", 32'(bus.q_count), 32'd0);
    applyStimulus(4'b0000, 1'b0);
    bus.weights[0] = 8'd1;
    settle(5);
    checkIdle("t6_end");

    // Reset mid-slice, then all four requesters queue in index order.
    applyStimulus(4'b1000, 1'b0);
    settle(2);
    checkOutput("t1_pre_id3", 32'(bus.grant_id), 32'd3);
    applyStimulus(4'b1111, 1'b0);
    settle(2);
    checkOutput("t1_pre_qcnt", 32'(bus.q_count), 32'd3);
    reset = 1'b0;
    tick();
    checkOutput("t1_rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("t1_rst_id", 32'(bus.grant_id), 32'd0);
    checkOutput("t1_rst_qcnt", 32'(bus.q_count), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("t1_qcnt4", 32'(bus.q_count), 32'd4);
    tick();
    checkOutput("t1_grant0", 32'(bus.grant), 32'b0001);
    checkOutput("t1_qcnt3", 32'(bus.q_count), 32'd3);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t1_order%0d", k), 32'(bus.grant_id), 32'(k));
      sliceLen(len); checkOutput($sformatf("t1_slice%0d", k), 32'(len), 32'd10);
      if (k < 3) begin
        gapLen(len); checkOutput($sformatf("t1_gap%0d", k), 32'(len), 32'd1);
      end
    end
    checkOutput("t1_starve", 32'(bus.starve_err), 32'd0);
    applyStimulus(4'b0000, 1'b0);
    settle(6);
    checkIdle("t1_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
